// File: rtl/digit_scroll_mux.sv
// digit_scroll_mux: 8-entry hex digit buffer with a slow left-rotate scroll
// and fast anode time-multiplexing, feeding an 8-digit seven-segment decoder.
module digit_scroll_mux #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned SCROLL_DIV  = 100000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] DIGIT_IN,
    input  logic       LOAD,
    input  logic       CLEAR,
    input  logic       SCROLL_EN,
    output logic [3:0] DIGIT_OUT,
    output logic [7:0] SSEG_AN,
    output logic       SCROLL_TICK
);
    localparam logic [31:0] REFRESH_LAST = REFRESH_DIV - 1;
    localparam logic [31:0] SCROLL_LAST  = SCROLL_DIV - 1;

    logic [31:0]     refresh_cnt_q, refresh_cnt_d;
    logic [31:0]     scroll_cnt_q, scroll_cnt_d;
    logic [2:0]      scan_idx_q, scan_idx_d;
    logic [7:0][3:0] digit_buf_q, digit_buf_d;
    logic [7:0]      valid_q, valid_d;
    logic [3:0]      digit_out_q, digit_out_d;
    logic [7:0]      sseg_an_q, sseg_an_d;
    logic            scroll_tick_q, scroll_tick_d;
    logic            refresh_wrap;
    logic            scroll_wrap;
    logic            scroll_tick_int;

    always_comb begin
        refresh_wrap    = (refresh_cnt_q == REFRESH_LAST);
        scroll_wrap     = (scroll_cnt_q == SCROLL_LAST);
        scroll_tick_int = scroll_wrap && SCROLL_EN;

        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 32'd1;
        scan_idx_d    = refresh_wrap ? scan_idx_q + 3'd1 : scan_idx_q;
        scroll_cnt_d  = scroll_wrap ? '0 : scroll_cnt_q + 32'd1;

        // CLEAR beats LOAD beats scroll; a tick that loses is simply dropped.
        digit_buf_d   = digit_buf_q;
        valid_d       = valid_q;
        scroll_tick_d = 1'b0;
        if (CLEAR) begin
            valid_d = '0;
        end else if (LOAD) begin
            digit_buf_d = {digit_buf_q[6:0], DIGIT_IN};
            valid_d     = {valid_q[6:0], 1'b1};
        end else if (scroll_tick_int) begin
            digit_buf_d   = {digit_buf_q[6:0], digit_buf_q[7]};
            valid_d       = {valid_q[6:0], valid_q[7]};
            scroll_tick_d = 1'b1;
        end

        // Outputs sample the pre-edge buffer, so they trail internal state by one cycle.
        digit_out_d = digit_buf_q[scan_idx_q];
        sseg_an_d   = valid_q[scan_idx_q] ? ~(8'b1 << scan_idx_q) : 8'hFF;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            refresh_cnt_q <= '0;
            scroll_cnt_q  <= '0;
            scan_idx_q    <= '0;
            digit_buf_q   <= '0;
            valid_q       <= '0;
            digit_out_q   <= '0;
            sseg_an_q     <= '1;
            scroll_tick_q <= 1'b0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            scroll_cnt_q  <= scroll_cnt_d;
            scan_idx_q    <= scan_idx_d;
            digit_buf_q   <= digit_buf_d;
            valid_q       <= valid_d;
            digit_out_q   <= digit_out_d;
            sseg_an_q     <= sseg_an_d;
            scroll_tick_q <= scroll_tick_d;
        end
    end

    assign DIGIT_OUT   = digit_out_q;
    assign SSEG_AN     = sseg_an_q;
    assign SCROLL_TICK = scroll_tick_q;
endmodule

// File: tb/tb_digit_scroll_mux.sv
// Bench for digit_scroll_mux: a behavioural model pushes the expected output
// word for every clock edge into a queue; scenario tasks pop and compare it.
module tb_digit_scroll_mux;
    localparam int RD = 4;
    localparam int SD = 16;

    // {DIGIT_OUT[3:0], SSEG_AN[7:0], SCROLL_TICK}
    typedef logic [12:0] obs_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] DIGIT_IN = 4'h0;
    logic       LOAD = 1'b0;
    logic       CLEAR = 1'b0;
    logic       SCROLL_EN = 1'b0;
    logic [3:0] DIGIT_OUT;
    logic [7:0] SSEG_AN;
    logic       SCROLL_TICK;

    int total = 0;
    int bad = 0;
    obs_t exp_q[$];

    int unsigned m_rcnt;
    int unsigned m_scnt;
    logic [2:0]  m_idx;
    logic [3:0]  m_buf [8];
    logic [7:0]  m_valid;

    digit_scroll_mux #(.REFRESH_DIV(RD), .SCROLL_DIV(SD)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .DIGIT_IN(DIGIT_IN),
        .LOAD(LOAD),
        .CLEAR(CLEAR),
        .SCROLL_EN(SCROLL_EN),
        .DIGIT_OUT(DIGIT_OUT),
        .SSEG_AN(SSEG_AN),
        .SCROLL_TICK(SCROLL_TICK)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t predict();
        logic [7:0] an;
        an = m_valid[m_idx] ? ~(8'b1 << m_idx) : 8'hFF;
        return {m_buf[m_idx], an, ((m_scnt == SD - 1) && SCROLL_EN && !CLEAR && !LOAD)};
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_rcnt  <= 0;
            m_scnt  <= 0;
            m_idx   <= 3'd0;
            m_valid <= 8'h00;
            for (int i = 0; i < 8; i++) m_buf[i] <= 4'h0;
            exp_q.delete();
        end else begin
            exp_q.push_back(predict());
            if (CLEAR) begin
                m_valid <= 8'h00;
            end else if (LOAD) begin
                for (int i = 1; i < 8; i++) m_buf[i] <= m_buf[i-1];
                m_buf[0] <= DIGIT_IN;
                m_valid  <= {m_valid[6:0], 1'b1};
            end else if ((m_scnt == SD - 1) && SCROLL_EN) begin
                for (int i = 0; i < 8; i++) m_buf[i] <= m_buf[(i + 7) % 8];
                m_valid <= {m_valid[6:0], m_valid[7]};
            end
            m_rcnt <= (m_rcnt == RD - 1) ? 0 : m_rcnt + 1;
            m_idx  <= (m_rcnt == RD - 1) ? m_idx + 3'd1 : m_idx;
            m_scnt <= (m_scnt == SD - 1) ? 0 : m_scnt + 1;
        end
    end

    function automatic obs_t observed();
        return {DIGIT_OUT, SSEG_AN, SCROLL_TICK};
    endfunction

    task automatic next_cycle(output obs_t e, output bit have);
        @(negedge CLK);
        have = (exp_q.size() > 0);
        e = '0;
        if (have) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        obs_t e, got;
        bit h;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        got = observed();
        total++;
        if (got !== {4'h0, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: got d=%h an=%h t=%b exp d=0 an=ff t=0", got[12:9], got[8:1], got[0]);
        end
        RST_N = 1'b1;
        for (int c = 0; c < 40; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL idle_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            total++;
            if (got !== {4'h0, 8'hFF, 1'b0}) begin
                bad++;
                $display("FAIL idle_blank: got d=%h an=%h t=%b exp d=0 an=ff t=0", got[12:9], got[8:1], got[0]);
            end
        end
    endtask

    task automatic test_load_pattern();
        obs_t e, got;
        bit h;
        int n_fe = 0, n_fd = 0, n_fb = 0, n_ff = 0;
        for (int k = 1; k <= 3; k++) begin
            LOAD = 1'b1;
            DIGIT_IN = 4'(k);
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL load_push_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
        end
        LOAD = 1'b0;
        DIGIT_IN = 4'h0;
        for (int c = 0; c < 40; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL load_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            case (got[8:1])
                8'hFE: begin
                    n_fe++;
                    total++;
                    if (got[12:9] !== 4'h3) begin bad++; $display("FAIL load_slot0: got %h exp 3", got[12:9]); end
                end
                8'hFD: begin
                    n_fd++;
                    total++;
                    if (got[12:9] !== 4'h2) begin bad++; $display("FAIL load_slot1: got %h exp 2", got[12:9]); end
                end
                8'hFB: begin
                    n_fb++;
                    total++;
                    if (got[12:9] !== 4'h1) begin bad++; $display("FAIL load_slot2: got %h exp 1", got[12:9]); end
                end
                8'hFF: n_ff++;
                default: begin
                    total++;
                    bad++;
                    $display("FAIL load_anode: got an=%h exp one of fe/fd/fb/ff", got[8:1]);
                end
            endcase
        end
        total++;
        if (n_fe < 4 || n_fd < 4 || n_fb < 4 || n_ff < 20) begin
            bad++;
            $display("FAIL load_windows: got fe=%0d fd=%0d fb=%0d ff=%0d exp >=4,>=4,>=4,>=20", n_fe, n_fd, n_fb, n_ff);
        end
    endtask

    task automatic test_scroll();
        obs_t e, got;
        bit h;
        int ticks = 0;
        int last = -1;
        for (int k = 7; k >= 0; k--) begin
            LOAD = 1'b1;
            DIGIT_IN = 4'(k);
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL scroll_load_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
        end
        LOAD = 1'b0;
        SCROLL_EN = 1'b1;
        for (int c = 0; c < 200 && ticks < 8; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL scroll_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            if (got[0]) begin
                if (last >= 0) begin
                    total++;
                    if (c - last != SD) begin bad++; $display("FAIL tick_period: got %0d exp %0d", c - last, SD); end
                end
                last = c;
                ticks++;
            end else if (ticks == 1) begin
                if (got[8:1] == 8'hFE) begin
                    total++;
                    if (got[12:9] !== 4'h7) begin bad++; $display("FAIL rot1_slot0: got %h exp 7", got[12:9]); end
                end
                if (got[8:1] == 8'hFD) begin
                    total++;
                    if (got[12:9] !== 4'h0) begin bad++; $display("FAIL rot1_slot1: got %h exp 0", got[12:9]); end
                end
            end
        end
        total++;
        if (ticks != 8) begin bad++; $display("FAIL scroll_ticks: got %0d exp 8", ticks); end
        SCROLL_EN = 1'b0;
        for (int c = 0; c < 33; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL restore_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            for (int k = 0; k < 8; k++) begin
                if (got[8:1] == ~(8'b1 << k)) begin
                    total++;
                    if (got[12:9] !== 4'(k)) begin bad++; $display("FAIL restore_slot%0d: got %h exp %h", k, got[12:9], 4'(k)); end
                end
            end
        end
    endtask

    task automatic test_load_tick_collision();
        obs_t e, got;
        bit h;
        bit found = 1'b0;
        int n = 0;
        SCROLL_EN = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_scnt == SD - 1) begin
                found = 1'b1;
            end else begin
                next_cycle(e, h);
                got = observed();
                total++;
                if (!h || got !== e) begin
                    bad++;
                    $display("FAIL coll_wait_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
                end
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL coll_align: got no terminal count exp one within 40 cycles"); end
        LOAD = 1'b1;
        DIGIT_IN = 4'h9;
        next_cycle(e, h);
        got = observed();
        LOAD = 1'b0;
        total++;
        if (!h || got !== e) begin
            bad++;
            $display("FAIL coll_edge_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
        end
        total++;
        if (got[0] !== 1'b0) begin bad++; $display("FAIL coll_tick_dropped: got %b exp 0", got[0]); end
        for (int c = 1; c <= 20 && n == 0; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL coll_after_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            if (got[0]) n = c;
            else if (got[8:1] == 8'hFE) begin
                total++;
                if (got[12:9] !== 4'h9) begin bad++; $display("FAIL coll_slot0: got %h exp 9", got[12:9]); end
            end
        end
        total++;
        if (n != SD) begin bad++; $display("FAIL coll_next_tick: got %0d exp %0d", n, SD); end
    endtask

    task automatic test_clear();
        obs_t e, got;
        bit h;
        int n_fe = 0;
        SCROLL_EN = 1'b0;
        CLEAR = 1'b1;
        next_cycle(e, h);
        got = observed();
        CLEAR = 1'b0;
        total++;
        if (!h || got !== e) begin
            bad++;
            $display("FAIL clear_edge_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
        end
        for (int c = 0; c < 33; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL clear_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            total++;
            if (got[8:1] !== 8'hFF) begin bad++; $display("FAIL clear_blank: got an=%h exp ff", got[8:1]); end
        end
        LOAD = 1'b1;
        DIGIT_IN = 4'hA;
        next_cycle(e, h);
        got = observed();
        LOAD = 1'b0;
        total++;
        if (!h || got !== e) begin
            bad++;
            $display("FAIL clear_load_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
        end
        for (int c = 0; c < 40; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL clear_after_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            if (got[8:1] == 8'hFE) begin
                n_fe++;
                total++;
                if (got[12:9] !== 4'hA) begin bad++; $display("FAIL clear_slot0: got %h exp a", got[12:9]); end
            end else if (got[8:1] != 8'hFF) begin
                total++;
                bad++;
                $display("FAIL clear_only_slot0: got an=%h exp fe or ff", got[8:1]);
            end
        end
        total++;
        if (n_fe < 4) begin bad++; $display("FAIL clear_slot0_seen: got %0d exp >=4", n_fe); end
    endtask

    task automatic test_async_reset();
        obs_t e, got;
        bit h;
        logic [7:0] an_tab [5] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
        logic [3:0] d_tab  [5] = '{4'h0, 4'hC, 4'hC, 4'hC, 4'h0};
        SCROLL_EN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            LOAD = 1'b1;
            DIGIT_IN = 4'(k + 5);
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL ares_load_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
        end
        LOAD = 1'b0;
        got = observed();
        for (int c = 0; c < 40 && got[8:1] == 8'hFF; c++) begin
            next_cycle(e, h);
            got = observed();
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL ares_run_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
        end
        total++;
        if (got[8:1] == 8'hFF) begin bad++; $display("FAIL ares_visible: got an=ff exp a lit anode before reset"); end
        #2;
        RST_N = 1'b0;
        #1;
        got = observed();
        total++;
        if (got !== {4'h0, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL async_reset_vals: got d=%h an=%h t=%b exp d=0 an=ff t=0", got[12:9], got[8:1], got[0]);
        end
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        @(negedge CLK);
        LOAD = 1'b1;
        DIGIT_IN = 4'hC;
        for (int c = 0; c < 5; c++) begin
            next_cycle(e, h);
            got = observed();
            LOAD = 1'b0;
            total++;
            if (!h || got !== e) begin
                bad++;
                $display("FAIL ares_post_sb: got d=%h an=%h t=%b exp d=%h an=%h t=%b", got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
            end
            total++;
            if (got[8:1] !== an_tab[c] || got[12:9] !== d_tab[c]) begin
                bad++;
                $display("FAIL ares_first_step c=%0d: got d=%h an=%h exp d=%h an=%h", c, got[12:9], got[8:1], d_tab[c], an_tab[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_pattern();
        test_scroll();
        test_load_tick_collision();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion exp finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
